shake_output_buffer: RTL and testbench
======================================

// Module: shake_output_buffer
// PURPOSE
//   Squeeze-side output buffer and length counter for the SHAKE core. Captures the rate
//   portion of the Keccak state in parallel and shifts it out one W-bit word at a time.
//   Tracks remaining requested output bits and masks the final partial word.
//   Driven by the dump FSM through output_buffer_shift_en / output_counter_*.
//   Feeds that FSM output_buffer_empty / output_size_reached.
// PARAMETERS
//   W         64   word / lane width in bits
//   MAX_LANES 21   buffer depth in lanes (SHAKE128 rate = 21 lanes, SHAKE256 rate = 17 lanes)
//   LEN_W     32   width of the requested-output-length field, in bits
// PORTS
//   clk                  in   1            clock, rising edge
//   rst                  in   1            asynchronous reset, active-low
//   mode                 in   1            0 = SHAKE128 (21 lanes), 1 = SHAKE256 (17 lanes)
//   len_load             in   1            start of request: load output_length_in, clear overrun_err
//   output_length_in     in   LEN_W        total requested output length in bits
//   state_in             in   MAX_LANES*W  rate lanes; lane i = state_in[i*W +: W]
//   output_buffer_we     in   1            parallel load of state_in into the lane array
//   output_counter_load  in   1            set lanes_left to 21 or 17, selected by mode
//   output_counter_rst   in   1            clear lanes_left to 0; buffer reads as empty
//   output_buffer_shift_en in 1            consume lane 0 and advance the array
//   data_out             out  W            lane 0 with masking applied
//   last_word_out        out  1            data_out is the final word of the request
//   output_buffer_empty  out  1            lanes_left == 0
//   output_size_reached  out  1            remaining == 0
//   squeeze_req          out  1            1-cycle pulse: next permutation needed
//   overrun_err          out  1            sticky: write arrived while unread lanes remained
// BEHAVIOUR
//   - Reset (rst = 0, asynchronous): lanes, lanes_left, remaining, squeeze_req and overrun_err are 0.
//     As a result data_out = 0, output_buffer_empty = 1, output_size_reached = 1, last_word_out = 0.
//   - Registers:
//     lane[0..MAX_LANES-1] (W bits each), lanes_left [4:0], remaining [LEN_W-1:0].
//   - Write:
//     output_buffer_we loads every lane from state_in at the edge.
//     lane 0 is visible on data_out in the next cycle; outputs are combinational from registers.
//     In SHAKE256 mode, lanes 17..20 are loaded but never emitted.
//   - lanes_left priority: output_counter_load > shift > output_counter_rst.
//     load + rst in the same cycle gives lanes_left = rate lanes.
//   - Shift:
//     A shift is accepted only when shift_en = 1, lanes_left != 0 and remaining != 0.
//     On accept: lane[i] <= lane[i+1], top lane <= 0, lanes_left decrements.
//     remaining <= (remaining > W) ? remaining - W : 0.
//     A shift request while empty or size_reached is ignored; no state changes.
//   - Same-cycle write + shift:
//     the write wins for the lane array; the shift still updates remaining and lanes_left,
//     unless output_counter_load is also asserted.
//   - Mask: when 0 < remaining < W, data_out[W-1:remaining] = 0.
//     Otherwise data_out = lane 0 unmasked.
//   - last_word_out = (remaining != 0) && (remaining <= W) && (lanes_left != 0).
//   - squeeze_req:
//     pulses for 1 cycle after an accepted shift leaves lanes_left = 0 with remaining != 0.
//     No pulse is issued when the request completes exactly on a block boundary.
//   - len_load:
//     remaining <= output_length_in and overrun_err <= 0; lanes are unaffected.
//     len_load has priority over a same-cycle shift decrement.
//     output_length_in = 0 leaves size_reached = 1 immediately.
//   - overrun_err is set when output_buffer_we = 1 while lanes_left != 0 and remaining != 0.
//   - Reset mid-stream: all registers clear immediately; the request is lost.
//     The next request needs len_load followed by a fresh write.
// TESTING
//   1. SHAKE128, len = 256, write lanes 0x11..0x15 + load, 4 shifts
//      -> data_out = 0x11..0x14; size_reached after the 4th shift; last_word on the 4th;
//         no squeeze_req.
//   2. SHAKE256, len = 1500: 17 shifts
//      -> empty = 1, one squeeze_req pulse, remaining = 412.
//      Reload, 7 shifts -> 7th word has bits [63:28] = 0; size_reached = 1.
//   3. SHAKE128, len = 1344
//      -> 21 shifts empty the buffer with size_reached = 1; no squeeze_req pulse.
//   4. shift_en held high while empty or size_reached
//      -> data_out, lanes_left and remaining stay unchanged.
//   5. Write + load while 3 lanes unread, remaining > 0
//      -> overrun_err = 1 and lanes_left = 21; a following len_load clears overrun_err.
//   6. rst low mid-stream (5 lanes left)
//      -> next cycle empty = 1, size_reached = 1, data_out = 0, squeeze_req = 0.

Source files
------------

// File: rtl/shake_output_buffer_if.sv
// shake_output_buffer_if: control and data bundle between the SHAKE dump FSM and the output buffer
//   master (FSM side) drives mode, len_load, output_length_in, state_in, output_buffer_we,
//   output_counter_load, output_counter_rst, output_buffer_shift_en; it observes data_out,
//   last_word_out, output_buffer_empty, output_size_reached, squeeze_req, overrun_err.
//   slave (buffer side) takes the opposite directions.
interface shake_output_buffer_if #(
    parameter int W         = 64,
    parameter int MAX_LANES = 21,
    parameter int LEN_W     = 32
);
    logic                   mode;
    logic                   len_load;
    logic [LEN_W-1:0]       output_length_in;
    logic [MAX_LANES*W-1:0] state_in;
    logic                   output_buffer_we;
    logic                   output_counter_load;
    logic                   output_counter_rst;
    logic                   output_buffer_shift_en;
    logic [W-1:0]           data_out;
    logic                   last_word_out;
    logic                   output_buffer_empty;
    logic                   output_size_reached;
    logic                   squeeze_req;
    logic                   overrun_err;

    modport master (
        output mode, len_load, output_length_in, state_in, output_buffer_we,
               output_counter_load, output_counter_rst, output_buffer_shift_en,
        input  data_out, last_word_out, output_buffer_empty, output_size_reached,
               squeeze_req, overrun_err
    );

    modport slave (
        input  mode, len_load, output_length_in, state_in, output_buffer_we,
               output_counter_load, output_counter_rst, output_buffer_shift_en,
        output data_out, last_word_out, output_buffer_empty, output_size_reached,
               squeeze_req, overrun_err
    );
endinterface

// File: rtl/shake_output_buffer.sv
// shake_output_buffer: squeeze-side rate buffer that shifts out W-bit words and tracks remaining output bits
//   clk  : rising-edge clock
//   rst  : asynchronous reset, active-low
//   bus  : shake_output_buffer_if.slave (parallel lane load, shift, length/lane counters, status)
module shake_output_buffer #(
    parameter int W         = 64,
    parameter int MAX_LANES = 21,
    parameter int LEN_W     = 32
) (
    input logic                  clk,
    input logic                  rst,
    shake_output_buffer_if.slave bus
);
    localparam logic [LEN_W-1:0] W_LEN = LEN_W'(W);

    logic [MAX_LANES*W-1:0] lanes;
    logic [4:0]             lanes_left, lanes_left_d, rate;
    logic [LEN_W-1:0]       remaining, remaining_d;
    logic                   accept, squeeze_q, overrun_q;
    logic [W-1:0]           mask;

    always_comb begin
        rate         = bus.mode ? 5'd17 : 5'd21;
        accept       = bus.output_buffer_shift_en && lanes_left != 5'd0 && remaining != '0;
        // counter load beats an accepted shift, which beats counter clear
        lanes_left_d = bus.output_counter_load ? rate :
                       accept ? lanes_left - 5'd1 :
                       bus.output_counter_rst ? 5'd0 : lanes_left;
        remaining_d  = bus.len_load ? bus.output_length_in :
                       accept ? (remaining > W_LEN ? remaining - W_LEN : '0) : remaining;
        // only meaningful when remaining < W, so the low log2(W) bits are the full count
        mask         = ~({W{1'b1}} << remaining[$clog2(W)-1:0]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lanes      <= '0;
            lanes_left <= 5'd0;
            remaining  <= '0;
            squeeze_q  <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            // a parallel write wins over a same-cycle shift for the lane array only
            lanes      <= bus.output_buffer_we ? bus.state_in :
                          accept ? {{W{1'b0}}, lanes[MAX_LANES*W-1:W]} : lanes;
            lanes_left <= lanes_left_d;
            remaining  <= remaining_d;
            squeeze_q  <= accept && lanes_left_d == 5'd0 && remaining_d != '0;
            overrun_q  <= bus.len_load ? 1'b0 :
                          (bus.output_buffer_we && lanes_left != 5'd0 && remaining != '0) ? 1'b1 :
                          overrun_q;
        end
    end

    assign bus.data_out            = (remaining != '0 && remaining < W_LEN) ? (lanes[W-1:0] & mask) : lanes[W-1:0];
    assign bus.last_word_out       = remaining != '0 && remaining <= W_LEN && lanes_left != 5'd0;
    assign bus.output_buffer_empty = lanes_left == 5'd0;
    assign bus.output_size_reached = remaining == '0;
    assign bus.squeeze_req         = squeeze_q;
    assign bus.overrun_err         = overrun_q;
endmodule

// File: tb/tb_shake_output_buffer.sv
// tb_shake_output_buffer: table-driven directed check of the SHAKE output buffer
module tb_shake_output_buffer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shake_output_buffer_if bus ();

    shake_output_buffer dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic        mode, ll;
        logic [31:0] len;
        logic        we, cl, cr, sh;
        int          pat;
        logic [63:0] d;
        logic        last, empty, size, sq, ovr;
    } vec_t;

    vec_t q[$];

    function automatic logic [63:0] p1(int k);
        return 64'h11 + 64'(k);
    endfunction

    function automatic logic [63:0] p2(int k);
        return 64'hFFFF_FFFF_FFFF_FF00 | 64'(k);
    endfunction

    function automatic logic [21*64-1:0] pat_data(int p);
        logic [21*64-1:0] s = '0;
        for (int i = 0; i < 21; i++) s[i*64 +: 64] = (p == 1) ? p1(i) : (p == 2) ? p2(i) : 64'h0;
        return s;
    endfunction

    task automatic add(input logic mode, ll, input logic [31:0] len, input logic we, cl, cr, sh,
                       input int pat, input logic [63:0] d, input logic last, empty, size, sq, ovr);
        vec_t v;
        v.mode = mode; v.ll = ll; v.len = len; v.we = we; v.cl = cl; v.cr = cr; v.sh = sh;
        v.pat = pat; v.d = d; v.last = last; v.empty = empty; v.size = size; v.sq = sq; v.ovr = ovr;
        q.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [63:0] d, input logic last, empty, size, sq, ovr);
        chk({tag, " data_out"}, bus.data_out, d);
        chk({tag, " last_word"}, 64'(bus.last_word_out), 64'(last));
        chk({tag, " empty"}, 64'(bus.output_buffer_empty), 64'(empty));
        chk({tag, " size_reached"}, 64'(bus.output_size_reached), 64'(size));
        chk({tag, " squeeze_req"}, 64'(bus.squeeze_req), 64'(sq));
        chk({tag, " overrun_err"}, 64'(bus.overrun_err), 64'(ovr));
    endtask

    task automatic drive(input logic mode, ll, input logic [31:0] len, input logic we, cl, cr, sh, input int pat);
        bus.mode = mode; bus.len_load = ll; bus.output_length_in = len;
        bus.output_buffer_we = we; bus.output_counter_load = cl; bus.output_counter_rst = cr;
        bus.output_buffer_shift_en = sh; bus.state_in = pat_data(pat);
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        // SHAKE128 len 256: four words, last flagged on the fourth, no squeeze
        add(0, 1, 256, 0, 0, 0, 0, 0, 64'h0, 0, 1, 0, 0, 0);
        add(0, 0, 0, 1, 1, 0, 0, 1, p1(0), 0, 0, 0, 0, 0);
        for (int k = 1; k <= 4; k++) add(0, 0, 0, 0, 0, 0, 1, 0, p1(k), k == 3, 0, k == 4, 0, 0);
        // shifts ignored while size reached, then while empty
        add(0, 0, 0, 0, 0, 0, 1, 0, p1(4), 0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0, 0, p1(4), 0, 1, 1, 0, 0);
        add(0, 1, 128, 0, 0, 0, 0, 0, p1(4), 0, 1, 0, 0, 0);
        for (int k = 0; k < 2; k++) add(0, 0, 0, 0, 0, 0, 1, 0, p1(4), 0, 1, 0, 0, 0);
        // SHAKE256 len 1500: 17 words then squeeze, reload, 7 words with final one masked to 28 bits
        add(1, 1, 1500, 0, 0, 0, 0, 0, p1(4), 0, 1, 0, 0, 0);
        add(1, 0, 0, 1, 1, 0, 0, 2, p2(0), 0, 0, 0, 0, 0);
        for (int k = 1; k <= 17; k++) add(1, 0, 0, 0, 0, 0, 1, 0, p2(k), 0, k == 17, 0, k == 17, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, p2(17), 0, 1, 0, 0, 0);
        add(1, 0, 0, 1, 1, 0, 0, 2, p2(0), 0, 0, 0, 0, 0);
        for (int k = 1; k <= 7; k++)
            add(1, 0, 0, 0, 0, 0, 1, 0, (k == 6) ? 64'h0000_0000_0FFF_FF06 : p2(k), k == 6, 0, k == 7, 0, 0);
        // SHAKE128 len 1344: exactly one block, no squeeze; counter load beats counter clear
        add(0, 0, 0, 0, 0, 1, 0, 0, p2(7), 0, 1, 1, 0, 0);
        add(0, 1, 1344, 0, 0, 0, 0, 0, p2(7), 0, 1, 0, 0, 0);
        add(0, 0, 0, 1, 1, 1, 0, 1, p1(0), 0, 0, 0, 0, 0);
        for (int k = 1; k <= 21; k++)
            add(0, 0, 0, 0, 0, 0, 1, 0, (k == 21) ? 64'h0 : p1(k), k == 20, k == 21, k == 21, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 64'h0, 0, 1, 1, 0, 0);
        // overrun: rewrite with 3 lanes unread, then len_load clears it
        add(0, 1, 2000, 0, 0, 0, 0, 0, 64'h0, 0, 1, 0, 0, 0);
        add(0, 0, 0, 1, 1, 0, 0, 1, p1(0), 0, 0, 0, 0, 0);
        for (int k = 1; k <= 18; k++) add(0, 0, 0, 0, 0, 0, 1, 0, p1(k), 0, 0, 0, 0, 0);
        add(0, 0, 0, 1, 1, 0, 0, 1, p1(0), 0, 0, 0, 0, 1);
        add(0, 1, 64, 0, 0, 0, 0, 0, p1(0), 1, 0, 0, 0, 0);
        // set up a stream with 5 lanes left for the reset sequence
        add(0, 0, 0, 0, 0, 1, 0, 0, p1(0), 0, 1, 0, 0, 0);
        add(0, 1, 2000, 0, 0, 0, 0, 0, p1(0), 0, 1, 0, 0, 0);
        add(0, 0, 0, 1, 1, 0, 0, 1, p1(0), 0, 0, 0, 0, 0);
        for (int k = 1; k <= 16; k++) add(0, 0, 0, 0, 0, 0, 1, 0, p1(k), 0, 0, 0, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 64'h0, 0, 1, 1, 0, 0);
        @(negedge clk);
        rst = 1'b1;

        foreach (q[i]) begin
            drive(q[i].mode, q[i].ll, q[i].len, q[i].we, q[i].cl, q[i].cr, q[i].sh, q[i].pat);
            @(posedge clk);
            #1;
            chk_all($sformatf("vec%0d", i), q[i].d, q[i].last, q[i].empty, q[i].size, q[i].sq, q[i].ovr);
        end

        // asynchronous reset mid-stream with 5 lanes left and shift still requested
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        #2;
        rst = 1'b0;
        #1;
        chk_all("async_rst", 64'h0, 0, 1, 1, 0, 0);
        @(posedge clk);
        #1;
        chk_all("rst_hold", 64'h0, 0, 1, 1, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        @(posedge clk);
        #1;
        chk_all("post_rst_shift", 64'h0, 0, 1, 1, 0, 0);
        // fresh request after reset
        drive(0, 1, 100, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk_all("post_rst_len", 64'h0, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 1, 1, 0, 0, 1);
        @(posedge clk);
        #1;
        chk_all("post_rst_write", p1(0), 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        @(posedge clk);
        #1;
        chk_all("post_rst_mask", 64'h0000_0000_0000_0012, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
